// File: rtl/led_pattern_seq.sv
// led_pattern_seq
//
// LED pattern sequencer for the board LED bank. A prescaler divides clk
// into a one-cycle tick. On every tick a small pattern state machine
// (current mode plus bounce direction) either loads the initial pattern
// of a newly selected mode or advances the pattern of the current mode.
//
// Ports:
//   clk       board clock (CLOCK_50)
//   rst       synchronous active-high reset, overrides every other input
//   div_val   new divider value, taken when div_load=1 and div_val!=0
//   div_load  one-cycle strobe loading div_val into the divider register
//   mode      pattern select: 00 OFF, 01 BLINK, 10 CHASE, 11 BOUNCE
//   pause     holds the prescaler count and suppresses tick while high
//   tick      registered, high for one cycle per divider period
//   leds      registered LED pattern (LEDG)
module led_pattern_seq #(
  parameter int LED_W       = 2,
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic             tick,
  output logic [LED_W-1:0] leds
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
  localparam logic [LED_W-1:0] ALL_ONES  = '1;
  localparam logic [LED_W-1:0] ONE_HOT0  = LED_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_reg;
  mode_t            cur_mode;
  dir_t             dir;
  mode_t            mode_sel;

  assign mode_sel = mode_t'(mode);

  // Prescaler. A non-zero load wins over pause and restarts the period;
  // a zero load is ignored so the divider can never be set to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      div_reg <= DIV_RESET;
    end else if (div_load && (div_val != '0)) begin
      div_reg <= div_val;
      cnt     <= '0;
      tick    <= 1'b0;
    end else if (pause) begin
      tick <= 1'b0;
    end else if (cnt == div_reg - DIV_ONE) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_ONE;
      tick <= 1'b0;
    end
  end

  // Pattern state machine. It only acts on the edge that closes a tick
  // cycle, so a new leds value appears one cycle after tick is high and
  // mode is effectively sampled only in tick cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode <= MODE_OFF;
      dir      <= DIR_LEFT;
      leds     <= '0;
    end else if (tick) begin
      if (mode_sel != cur_mode) begin
        cur_mode <= mode_sel;
        dir      <= DIR_LEFT;
        case (mode_sel)
          MODE_OFF:    leds <= '0;
          MODE_BLINK:  leds <= ALL_ONES;
          MODE_CHASE:  leds <= ONE_HOT0;
          MODE_BOUNCE: leds <= ONE_HOT0;
        endcase
      end else begin
        case (cur_mode)
          MODE_OFF:   leds <= '0;
          MODE_BLINK: leds <= ~leds;
          // Rotate left; the MSB wraps to bit 0. With one LED this is
          // a no-op, which keeps the single bit lit.
          MODE_CHASE: leds <= (leds << 1) | (leds >> (LED_W - 1));
          MODE_BOUNCE: begin
            if (LED_W == 1) begin
              leds <= ONE_HOT0;
            end else if (dir == DIR_LEFT) begin
              // Turning at the top end moves straight to the next bit
              // down so the end bit is shown only once.
              if (leds[LED_W-1]) begin
                dir  <= DIR_RIGHT;
                leds <= leds >> 1;
              end else begin
                leds <= leds << 1;
              end
            end else begin
              if (leds[0]) begin
                dir  <= DIR_LEFT;
                leds <= leds << 1;
              end else begin
                leds <= leds >> 1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: three instances (LED_W = 1, 2, 4) share one
// stimulus stream. A behavioural model computes tick from a
// "cycles left in the period" countdown and leds from the number of ticks
// seen since the current mode was entered; a negedge process compares all
// instances against it every cycle. Directed scenarios add hand-computed
// literal expectations.
module tb_led_pattern_seq;

  localparam int DIV_W = 26;
  localparam int DEF   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             pause = 1'b0;

  logic       tick1, tick2, tick4;
  logic [0:0] leds1;
  logic [1:0] leds2;
  logic [3:0] leds4;

  // clock/reset block
  always #5 clk = ~clk;

  led_pattern_seq #(.LED_W(1), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) u_dut1 (
    .clk(clk), .rst(rst), .div_val(div_val), .div_load(div_load),
    .mode(mode), .pause(pause), .tick(tick1), .leds(leds1));
  led_pattern_seq #(.LED_W(2), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) u_dut2 (
    .clk(clk), .rst(rst), .div_val(div_val), .div_load(div_load),
    .mode(mode), .pause(pause), .tick(tick2), .leds(leds2));
  led_pattern_seq #(.LED_W(4), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) u_dut4 (
    .clk(clk), .rst(rst), .div_val(div_val), .div_load(div_load),
    .mode(mode), .pause(pause), .tick(tick4), .leds(leds4));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  // behavioural model state
  int m_div  = DEF;
  int m_left = DEF;   // counting cycles still needed before the next tick
  bit m_tick = 1'b0;
  int m_mode = 0;
  int m_step = 0;     // ticks seen since m_mode was entered

  // expected pattern after 'step' advances within mode 'md' on w LEDs
  function automatic logic [3:0] exp_leds(input int md, input int step, input int w);
    int p;
    int idx;
    logic [3:0] r;
    r = '0;
    idx = 0;
    case (md)
      1: if (step % 2 == 0) r = 4'((1 << w) - 1);
      2: r = 4'(1 << (step % w));
      3: begin
        if (w > 1) begin
          p   = step % (2 * w - 2);
          idx = (p < w) ? p : (2 * w - 2 - p);
        end
        r = 4'(1 << idx);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
  endtask

  // model update on every active edge, from the inputs the DUT samples
  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; m_div = DEF; m_left = DEF; m_tick = 1'b0; m_mode = 0; m_step = 0;
    end else begin
      cyc++;
      if (m_tick) begin
        if (int'(mode) != m_mode) begin
          m_mode = int'(mode);
          m_step = 0;
        end else begin
          m_step++;
        end
      end
      if (div_load && div_val != '0) begin
        m_div = int'(div_val); m_left = m_div; m_tick = 1'b0;
      end else if (pause) begin
        m_tick = 1'b0;
      end else begin
        m_left--;
        m_tick = (m_left == 0);
        if (m_left == 0) m_left = m_div;
      end
    end
  end

  // scoreboard compare process
  logic [3:0] e1, e2, e4;
  always @(negedge clk) begin
    if (check_en) begin
      e1 = exp_leds(m_mode, m_step, 1);
      e2 = exp_leds(m_mode, m_step, 2);
      e4 = exp_leds(m_mode, m_step, 4);
      check("tick_w1", {31'b0, tick1}, {31'b0, m_tick});
      check("tick_w2", {31'b0, tick2}, {31'b0, m_tick});
      check("tick_w4", {31'b0, tick4}, {31'b0, m_tick});
      check("leds_w1", {31'b0, leds1}, {31'b0, e1[0]});
      check("leds_w2", {30'b0, leds2}, {30'b0, e2[1:0]});
      check("leds_w4", {28'b0, leds4}, {28'b0, e4});
    end
  end

  // driver tasks
  task automatic do_reset(input logic [1:0] md);
    @(posedge clk); #1;
    rst = 1'b1; mode = md; div_load = 1'b0; pause = 1'b0; div_val = '0;
    @(posedge clk); #1;
    rst = 1'b0;   // now inside cycle 0
  endtask

  // advance to 1 time unit after the edge that starts cycle c
  task automatic goto_cycle(input int c);
    int g;
    g = 0;
    while (cyc != c && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (cyc != c) begin
      n_checks++;
      $display("FAIL goto: cycle %0d not reached (now %0d)", c, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] ch4 [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [1:0] ch2 [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
  logic [3:0] bn4 [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

  initial begin
    repeat (2) @(posedge clk);

    // BLINK from reset: ticks at 4, 8, 12
    do_reset(2'b01);
    check_en = 1'b1;
    check("reset_tick", {31'b0, tick2}, 32'd0);
    check("reset_leds", {28'b0, leds4}, 32'd0);
    goto_cycle(3);  check("blink_c3_tick", {31'b0, tick2}, 32'd0);
    goto_cycle(4);  check("blink_c4_tick", {31'b0, tick2}, 32'd1);
                    check("blink_c4_leds", {30'b0, leds2}, 32'd0);
    goto_cycle(5);  check("blink_c5_leds", {30'b0, leds2}, 32'd3);
    goto_cycle(8);  check("blink_c8_tick", {31'b0, tick2}, 32'd1);
    goto_cycle(9);  check("blink_c9_leds", {30'b0, leds2}, 32'd0);
    goto_cycle(12); check("blink_c12_tick", {31'b0, tick2}, 32'd1);
    goto_cycle(13); check("blink_c13_leds", {30'b0, leds2}, 32'd3);

    // CHASE on 1, 2 and 4 LEDs
    do_reset(2'b10);
    for (int k = 0; k < 5; k++) begin
      goto_cycle(5 + 4 * k);
      check("chase_w2", {30'b0, leds2}, {30'b0, ch2[k]});
      check("chase_w4", {28'b0, leds4}, {28'b0, ch4[k]});
      check("chase_w1", {31'b0, leds1}, 32'd1);
    end

    // BOUNCE on 4 LEDs, then switch to BLINK between ticks
    do_reset(2'b11);
    for (int k = 0; k < 8; k++) begin
      goto_cycle(5 + 4 * k);
      check("bounce_w4", {28'b0, leds4}, {28'b0, bn4[k]});
    end
    goto_cycle(34); mode = 2'b01;
    goto_cycle(36); check("bounce_hold", {28'b0, leds4}, 32'h2);
    goto_cycle(37); check("bounce_to_blink", {28'b0, leds4}, 32'hf);

    // divider load at the edge closing cycle 5: ticks 8, 10, 12; zero load ignored
    do_reset(2'b01);
    goto_cycle(5);  div_load = 1'b1; div_val = 26'd2;
    goto_cycle(6);  div_load = 1'b0;
    goto_cycle(7);  check("load_c7_tick", {31'b0, tick2}, 32'd0);
    goto_cycle(8);  check("load_c8_tick", {31'b0, tick2}, 32'd1);
    goto_cycle(9);  check("load_c9_tick", {31'b0, tick2}, 32'd0);
    goto_cycle(10); check("load_c10_tick", {31'b0, tick2}, 32'd1);
    goto_cycle(12); check("load_c12_tick", {31'b0, tick2}, 32'd1);
    goto_cycle(13); div_load = 1'b1; div_val = '0;
    goto_cycle(14); div_load = 1'b0;
                    check("load0_c14_tick", {31'b0, tick2}, 32'd1);
    goto_cycle(15); check("load0_c15_tick", {31'b0, tick2}, 32'd0);
    goto_cycle(16); check("load0_c16_tick", {31'b0, tick2}, 32'd1);

    // pause for cycles 2..11: count held at 2, next tick at 14
    do_reset(2'b01);
    goto_cycle(2);  pause = 1'b1;
    goto_cycle(4);  check("pause_c4_tick", {31'b0, tick2}, 32'd0);
    goto_cycle(12); pause = 1'b0;
                    check("pause_c12_tick", {31'b0, tick2}, 32'd0);
    goto_cycle(13); check("pause_c13_tick", {31'b0, tick2}, 32'd0);
                    check("pause_c13_leds", {30'b0, leds2}, 32'd0);
    goto_cycle(14); check("pause_c14_tick", {31'b0, tick2}, 32'd1);
    goto_cycle(15); check("pause_c15_leds", {30'b0, leds2}, 32'd3);

    // load together with pause: period restarts, then held until release
    do_reset(2'b01);
    goto_cycle(1);  pause = 1'b1; div_load = 1'b1; div_val = 26'd3;
    goto_cycle(2);  div_load = 1'b0;
    goto_cycle(5);  pause = 1'b0;
    goto_cycle(7);  check("lp_c7_tick", {31'b0, tick2}, 32'd0);
    goto_cycle(8);  check("lp_c8_tick", {31'b0, tick2}, 32'd1);

    // reset mid-BOUNCE with divider at 2: divider returns to default
    do_reset(2'b11);
    div_load = 1'b1; div_val = 26'd2;
    goto_cycle(1);  div_load = 1'b0;
    goto_cycle(8);  check("rb_c8_leds", {28'b0, leds4}, 32'h4);
    goto_cycle(9);  rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rb_c0_leds", {28'b0, leds4}, 32'h0);
    check("rb_c0_tick", {31'b0, tick4}, 32'd0);
    goto_cycle(2);  check("rb_c2_tick", {31'b0, tick4}, 32'd0);
    goto_cycle(4);  check("rb_c4_tick", {31'b0, tick4}, 32'd1);
    goto_cycle(5);  check("rb_c5_leds", {28'b0, leds4}, 32'h1);

    // randomized stimulus against the model
    do_reset(2'($urandom_range(0, 3)));
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      pause    = ($urandom_range(0, 9) == 0);
      div_load = ($urandom_range(0, 15) == 0);
      div_val  = DIV_W'($urandom_range(0, 5));
    end
    @(posedge clk); #1;
    rst = 1'b0; div_load = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
